// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment display: waits for each
// anode/segment dwell to be stable, decodes the hex glyph, and holds it per digit.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic [3:0]  blank,
  output logic        bad_pattern,
  output logic        frame_done,
  output logic [4:0]  dbg_state
);

  typedef enum logic {COLLECTING = 1'b0, COMPLETE = 1'b1} frame_state_t;

  localparam logic [7:0]  STABLE_N    = 8'(STABLE_CYCLES);
  localparam logic [10:0] IDLE_SAMPLE = 11'h7FF;

  // Returns {legal, value}; legal is 0 for anything outside the hex glyph set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h40: decode_glyph = 5'h10;
      7'h79: decode_glyph = 5'h11;
      7'h24: decode_glyph = 5'h12;
      7'h30: decode_glyph = 5'h13;
      7'h19: decode_glyph = 5'h14;
      7'h12: decode_glyph = 5'h15;
      7'h02: decode_glyph = 5'h16;
      7'h78: decode_glyph = 5'h17;
      7'h00: decode_glyph = 5'h18;
      7'h10: decode_glyph = 5'h19;
      7'h08: decode_glyph = 5'h1A;
      7'h03: decode_glyph = 5'h1B;
      7'h46: decode_glyph = 5'h1C;
      7'h21: decode_glyph = 5'h1D;
      7'h06: decode_glyph = 5'h1E;
      7'h0E: decode_glyph = 5'h1F;
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  logic [10:0]  samp_q, samp_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [15:0]  digits_q, digits_d;
  logic [3:0]   valid_q, valid_d;
  logic [3:0]   blank_q, blank_d;
  logic [3:0]   seen_q, seen_d;
  logic         bad_q, bad_d;
  logic         frame_q, frame_d;
  frame_state_t state_q, state_d;

  logic         same;
  logic         capture;
  logic [3:0]   cap_an;
  logic [6:0]   cap_seg;
  logic [4:0]   glyph;
  logic [1:0]   sel;
  logic         sel_valid;

  always_comb begin
    samp_d    = {an, seg};
    same      = (samp_d == samp_q);
    cap_an    = samp_q[10:7];
    cap_seg   = samp_q[6:0];
    glyph     = decode_glyph(cap_seg);

    // cnt saturates at STABLE_N, so the capture condition is met once per dwell.
    capture   = same && (cnt_q != STABLE_N) && ((cnt_q + 8'd1) == STABLE_N);
    if (!same)                 cnt_d = 8'd0;
    else if (cnt_q != STABLE_N) cnt_d = cnt_q + 8'd1;
    else                       cnt_d = cnt_q;

    sel       = 2'd0;
    sel_valid = 1'b1;
    case (cap_an)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_valid = 1'b0;
    endcase

    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    seen_d   = seen_q;
    bad_d    = 1'b0;
    frame_d  = 1'b0;
    state_d  = COLLECTING;

    if (capture) begin
      if (sel_valid) begin
        if (glyph[4]) begin
          digits_d[{sel, 2'b00} +: 4] = glyph[3:0];
          valid_d[sel] = 1'b1;
          blank_d[sel] = 1'b0;
        end else if (cap_seg == 7'h7F) begin
          valid_d[sel] = 1'b0;
          blank_d[sel] = 1'b1;
        end else begin
          valid_d[sel] = 1'b0;
          blank_d[sel] = 1'b0;
          bad_d        = 1'b1;
        end
        seen_d[sel] = 1'b1;
        if (seen_d == 4'hF) begin
          frame_d = 1'b1;
          seen_d  = 4'h0;
          state_d = COMPLETE;
        end
      end else if (cap_an != 4'hF) begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= IDLE_SAMPLE;
      cnt_q    <= 8'd0;
      digits_q <= 16'h0000;
      valid_q  <= 4'h0;
      blank_q  <= 4'h0;
      seen_q   <= 4'h0;
      bad_q    <= 1'b0;
      frame_q  <= 1'b0;
      state_q  <= COLLECTING;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      seen_q   <= seen_d;
      bad_q    <= bad_d;
      frame_q  <= frame_d;
      state_q  <= state_d;
    end
  end

  assign digits      = digits_q;
  assign valid       = valid_q;
  assign blank       = blank_q;
  assign bad_pattern = bad_q;
  assign frame_done  = frame_q;
  assign dbg_state   = {state_q, seen_q};

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder, checked every cycle against
// a dwell-length reference model built on a glyph lookup table.
`timescale 1ns/100ps
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic        bad_pattern;
  logic        frame_done;
  logic [4:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .digits(digits), .valid(valid), .blank(blank),
    .bad_pattern(bad_pattern), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: what the display has shown, and for how many edges.
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_dig [4];
  bit          m_val [4];
  bit          m_blk [4];
  bit          m_seen [4];
  bit          e_bad, e_frame;

  task automatic model_reset();
    m_last = 11'h7FF;
    m_run  = 1;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_val[i] = 0; m_blk[i] = 0; m_seen[i] = 0;
    end
    e_bad = 0; e_frame = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int zeros, idx, found, all_seen;
    e_bad = 0; e_frame = 0;
    if ({a, s} == m_last) m_run++;
    else begin m_last = {a, s}; m_run = 1; end
    if (m_run == S + 1) begin
      zeros = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
      if (zeros >= 2) e_bad = 1;
      else if (zeros == 1) begin
        found = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == s) found = g;
        if (found >= 0) begin
          m_dig[idx] = 4'(found); m_val[idx] = 1; m_blk[idx] = 0;
        end else if (s == 7'h7F) begin
          m_val[idx] = 0; m_blk[idx] = 1;
        end else begin
          m_val[idx] = 0; m_blk[idx] = 0; e_bad = 1;
        end
        m_seen[idx] = 1;
        all_seen = 1;
        for (int i = 0; i < 4; i++) if (!m_seen[i]) all_seen = 0;
        if (all_seen == 1) begin
          e_frame = 1;
          for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] ed;
    logic [3:0]  ev, eb;
    for (int i = 0; i < 4; i++) begin
      ed[4*i +: 4] = m_dig[i];
      ev[i] = m_val[i];
      eb[i] = m_blk[i];
    end
    chk("digits", digits, ed);
    chk("valid", {12'h0, valid}, {12'h0, ev});
    chk("blank", {12'h0, blank}, {12'h0, eb});
    chk("bad_pattern", {15'h0, bad_pattern}, {15'h0, e_bad});
    chk("frame_done", {15'h0, frame_done}, {15'h0, e_frame});
  endtask

  // Drive one sample slot: inputs change away from the edge, outputs checked #1 after it.
  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge(a, s);
    check_all();
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) step(a, s);
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("zero_digits_in_reset", digits, 16'h0000);
    #1 rst_n = 1'b1;
  endtask

  int frame_cnt;
  logic [3:0] ra;
  logic [6:0] rs;
  int r, len;

  initial begin
    model_reset();
    an = 4'b1110; seg = 7'h79;
    #3 check_all();
    step(4'b1110, 7'h79);
    step(4'b1110, 7'h79);
    #1 rst_n = 1'b1;

    // Reset then idle: digit 0 shows '1'
    dwell(4'b1110, 7'h79, 5);
    chk("tp_reset_digit0", {12'h0, digits[3:0]}, 16'h0001);
    chk("tp_reset_valid", {12'h0, valid}, 16'h0001);

    // Full scan 3, A, 0, F with exactly one frame pulse
    frame_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 6; k++) begin
        case (d)
          0: step(4'b1110, glyph[3]);
          1: step(4'b1101, glyph[10]);
          2: step(4'b1011, glyph[0]);
          default: step(4'b0111, glyph[15]);
        endcase
        if (frame_done) frame_cnt++;
      end
    end
    chk("tp_scan_digits", digits, 16'hF0A3);
    chk("tp_scan_frames", 16'(frame_cnt), 16'd1);

    // Glitch shorter than the stability window
    dwell(4'b1101, 7'h00, 3);
    dwell(4'b1111, 7'h7F, 6);
    chk("tp_glitch_digit1", {12'h0, digits[7:4]}, 16'h000A);

    // Illegal anode and illegal glyph
    dwell(4'b1100, 7'h40, 6);
    dwell(4'b1110, 7'h2A, 6);
    chk("tp_illegal_keep", {12'h0, digits[3:0]}, 16'h0003);
    // Blank digit 2
    dwell(4'b1011, 7'h7F, 6);
    chk("tp_blank2", {12'h0, blank}, 16'h0004);

    // Capture digits 0..2, reset mid-frame, then a full scan is needed again
    dwell(4'b1110, glyph[5], 6);
    dwell(4'b1101, glyph[6], 6);
    dwell(4'b1011, glyph[7], 3);
    async_reset_pulse();
    dwell(4'b1011, glyph[7], 6);
    dwell(4'b0111, glyph[8], 6);
    dwell(4'b1110, glyph[9], 6);
    dwell(4'b1101, glyph[11], 6);
    dwell(4'b1011, glyph[12], 6);

    // Randomized dwells, including short ones and occasional reset
    for (int t = 0; t < 250; t++) begin
      len = $urandom_range(1, 7);
      r = $urandom_range(0, 5);
      case (r)
        0: ra = 4'b1110;
        1: ra = 4'b1101;
        2: ra = 4'b1011;
        3: ra = 4'b0111;
        4: ra = 4'b1111;
        default: ra = 4'($urandom_range(0, 15));
      endcase
      r = $urandom_range(0, 9);
      if (r < 7) rs = glyph[$urandom_range(0, 15)];
      else if (r == 7) rs = 7'h7F;
      else rs = 7'($urandom_range(0, 127));
      dwell(ra, rs, len);
      if ($urandom_range(0, 39) == 0) async_reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
